// File: rtl/mux_n_to_1_reg_pkg.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_reg_pkg
//   Shared definitions for the registered N:1 multiplexer.
//   - Mode encodings (`MUX_MODE_MANUAL / `MUX_MODE_AUTO), guarded so that any
//     file of the block may reference them once this file is compiled first.
//   - Enumerated view of the mode bit.
//   - Default parameter values.
//   No ports (package).
// ---------------------------------------------------------------------------
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH
`define MUX_MODE_MANUAL 1'b0
`define MUX_MODE_AUTO   1'b1
`endif

package mux_n_to_1_reg_pkg;

    typedef enum logic {
        MUX_MANUAL = `MUX_MODE_MANUAL,
        MUX_AUTO   = `MUX_MODE_AUTO
    } mux_mode_e;

    localparam int MUX_DEF_WIDTH = 8;
    localparam int MUX_DEF_N     = 8;
    localparam int MUX_DEF_SEL_W = 3;

endpackage

// File: rtl/mux_n_to_1_comb.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_comb
//   Pure combinational N:1 selector. Picks channel i_c out of N channels and
//   returns its data word, valid bit and enable bit. o_hit is high only when
//   i_c addresses an existing channel (i_c < N); for out-of-range indices all
//   outputs are zero, so non-power-of-2 N never reads past the bus.
// Ports
//   i_data  [N*WIDTH-1:0]  channel k at [k*WIDTH +: WIDTH]
//   i_valid [N-1:0]        per-channel valid
//   i_en    [N-1:0]        per-channel enable mask
//   i_c     [SEL_W-1:0]    channel index
//   o_data  [WIDTH-1:0]    selected data
//   o_valid                selected valid
//   o_en                   selected enable
//   o_hit                  i_c is a legal channel
// ---------------------------------------------------------------------------
module mux_n_to_1_comb #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [N-1:0]       i_valid,
    input  logic [N-1:0]       i_en,
    input  logic [SEL_W-1:0]   i_c,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_valid,
    output logic               o_en,
    output logic               o_hit
);

    // Compare-and-pick rather than a direct index so an index >= N simply
    // matches nothing.
    always_comb begin
        o_data  = '0;
        o_valid = 1'b0;
        o_en    = 1'b0;
        o_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (i_c == SEL_W'(k)) begin
                o_data  = i_data[k*WIDTH +: WIDTH];
                o_valid = i_valid[k];
                o_en    = i_en[k];
                o_hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_reg.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_reg
//   Registered N:1 multiplexer with valid/ready output handshake.
//   Manual mode takes the channel from sel; auto mode scans channels with an
//   internal round-robin pointer, skipping disabled channels. The winning
//   word is loaded into a one-deep output register and the source channel is
//   acknowledged combinationally in the capture cycle.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mode       0 manual (sel), 1 auto-scan (pointer)
//   sel        manual channel select
//   ch_en      per-channel enable, auto mode only
//   in_data    N channels of WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ack     one-hot acknowledge, high in the capture cycle
//   out_data   registered selected data
//   out_ch     registered channel index of out_data
//   out_valid  output register holds a word
//   out_ready  sink accepts the word when out_valid && out_ready
// ---------------------------------------------------------------------------
module mux_n_to_1_reg
    import mux_n_to_1_reg_pkg::*;
#(
    parameter int WIDTH = MUX_DEF_WIDTH,
    parameter int N     = MUX_DEF_N,
    parameter int SEL_W = MUX_DEF_SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       ch_en,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ack,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;

    logic             w_auto;
    logic             w_free;
    logic [SEL_W-1:0] w_c;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_valid;
    logic             w_sel_en;
    logic             w_hit;
    logic             w_capture;
    logic [SEL_W-1:0] w_ptr_nxt;

    assign w_auto = (mode == `MUX_MODE_AUTO);

    // Slot is free when empty or being drained this very cycle; this lets a
    // drain and a capture share one edge with no bubble.
    assign w_free = !r_out_valid || out_ready;

    assign w_c = w_auto ? r_ptr : sel;

    mux_n_to_1_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_sel (
        .i_data  (in_data),
        .i_valid (in_valid),
        .i_en    (ch_en),
        .i_c     (w_c),
        .o_data  (w_sel_data),
        .o_valid (w_sel_valid),
        .o_en    (w_sel_en),
        .o_hit   (w_hit)
    );

    // The enable mask only gates auto mode. rst is folded in so in_ack stays
    // low while reset is held (the flops alone would report a free slot).
    assign w_capture = !rst && w_free && w_hit && w_sel_valid && (!w_auto || w_sel_en);

    always_comb begin
        in_ack = '0;
        for (int k = 0; k < N; k++) begin
            if (w_capture && (w_c == SEL_W'(k))) begin
                in_ack[k] = 1'b1;
            end
        end
    end

    // Explicit wrap at N-1 so non-power-of-2 channel counts never visit an
    // unused index.
    assign w_ptr_nxt = (r_ptr == SEL_W'(N-1)) ? '0 : r_ptr + SEL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_out_data  <= w_sel_data;
                r_out_ch    <= w_c;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Pointer moves on every free auto cycle, captured or not, so a
            // masked or idle channel costs exactly one slot.
            if (w_auto && w_free) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
module tb_mux_n_to_1_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: N=8
    logic        m8_mode, m8_rdy;
    logic [2:0]  m8_sel;
    logic [7:0]  m8_en, m8_vin, d8_ack;
    logic [63:0] m8_din;
    logic [7:0]  d8_data;
    logic [2:0]  d8_ch;
    logic        d8_v;

    // DUT B: N=5 (non power of 2)
    logic        m5_mode, m5_rdy;
    logic [2:0]  m5_sel;
    logic [4:0]  m5_en, m5_vin, d5_ack;
    logic [39:0] m5_din;
    logic [7:0]  d5_data;
    logic [2:0]  d5_ch;
    logic        d5_v;

    mux_n_to_1_reg #(.WIDTH(8), .N(8), .SEL_W(3)) dut8 (
        .clk(clk), .rst(rst), .mode(m8_mode), .sel(m8_sel), .ch_en(m8_en),
        .in_data(m8_din), .in_valid(m8_vin), .in_ack(d8_ack),
        .out_data(d8_data), .out_ch(d8_ch), .out_valid(d8_v), .out_ready(m8_rdy)
    );

    mux_n_to_1_reg #(.WIDTH(8), .N(5), .SEL_W(3)) dut5 (
        .clk(clk), .rst(rst), .mode(m5_mode), .sel(m5_sel), .ch_en(m5_en),
        .in_data(m5_din), .in_valid(m5_vin), .in_ack(d5_ack),
        .out_data(d5_data), .out_ch(d5_ch), .out_valid(d5_v), .out_ready(m5_rdy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: abstract state of the output slot plus scan pointer.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [2:0] ch;
        int         ptr;
    } mstate_t;

    mstate_t st8, st5;
    logic [7:0] ack8, ack5;

    function automatic void model(input mstate_t s, input int n, input logic mode,
                                  input logic [2:0] sel, input logic [7:0] en,
                                  input logic [63:0] din, input logic [7:0] vin,
                                  input logic rdy, output logic [7:0] ack,
                                  output mstate_t ns);
        logic free, cap;
        int   c;
        free = !s.v || rdy;
        c    = mode ? s.ptr : int'(sel);
        cap  = free && (c < n) && vin[c] && (!mode || en[c]);
        ack  = cap ? 8'(1 << c) : 8'h00;
        ns   = s;
        if (cap) begin
            ns.v  = 1'b1;
            ns.d  = din[c*8 +: 8];
            ns.ch = 3'(c);
        end else if (rdy) begin
            ns.v = 1'b0;
        end
        if (mode && free) ns.ptr = (s.ptr + 1) % n;
    endfunction

    task automatic reset_models();
        st8.v = 1'b0; st8.d = '0; st8.ch = '0; st8.ptr = 0;
        st5.v = 1'b0; st5.d = '0; st5.ch = '0; st5.ptr = 0;
    endtask

    // Called shortly after a rising edge with inputs already applied.
    task automatic step();
        logic [7:0] ea8, ea5;
        mstate_t    n8, n5;
        @(negedge clk);
        model(st8, 8, m8_mode, m8_sel, m8_en, m8_din, m8_vin, m8_rdy, ea8, n8);
        model(st5, 5, m5_mode, m5_sel, {3'b0, m5_en}, {24'b0, m5_din}, {3'b0, m5_vin}, m5_rdy, ea5, n5);
        ack8 = d8_ack;
        ack5 = {3'b0, d5_ack};
        chk("ack8", 64'(d8_ack), 64'(ea8));
        chk("ack5", 64'(d5_ack), 64'(ea5[4:0]));
        @(posedge clk);
        #1;
        st8 = n8;
        st5 = n5;
        chk("valid8", 64'(d8_v), 64'(st8.v));
        chk("data8",  64'(d8_data), 64'(st8.d));
        chk("ch8",    64'(d8_ch), 64'(st8.ch));
        chk("valid5", 64'(d5_v), 64'(st5.v));
        chk("data5",  64'(d5_data), 64'(st5.d));
        chk("ch5",    64'(d5_ch), 64'(st5.ch));
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [7:0] vin;
        logic [7:0] exp_ack;
        logic       exp_v;
        logic [7:0] exp_d;
        logic [2:0] exp_ch;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int caps;
        logic [7:0] hd;
        logic [2:0] hc;

        tbl[0] = '{3'd5, 8'h20, 8'h20, 1'b1, 8'hA5, 3'd5};
        tbl[1] = '{3'd5, 8'h00, 8'h00, 1'b0, 8'hA5, 3'd5};
        tbl[2] = '{3'd0, 8'h01, 8'h01, 1'b1, 8'hA0, 3'd0};
        tbl[3] = '{3'd7, 8'hFF, 8'h80, 1'b1, 8'hA7, 3'd7};
        tbl[4] = '{3'd3, 8'hF7, 8'h00, 1'b0, 8'hA7, 3'd7};
        tbl[5] = '{3'd2, 8'h04, 8'h04, 1'b1, 8'hA2, 3'd2};
        tbl[6] = '{3'd6, 8'h40, 8'h40, 1'b1, 8'hA6, 3'd6};
        tbl[7] = '{3'd1, 8'h02, 8'h02, 1'b1, 8'hA1, 3'd1};

        m8_mode = 1'b0; m8_sel = 3'd0; m8_en = 8'hFF; m8_vin = 8'hFF; m8_rdy = 1'b1;
        m5_mode = 1'b0; m5_sel = 3'd0; m5_en = 5'h1F; m5_vin = 5'h1F; m5_rdy = 1'b1;
        for (int k = 0; k < 8; k++) m8_din[k*8 +: 8] = 8'hA0 | 8'(k);
        for (int k = 0; k < 5; k++) m5_din[k*8 +: 8] = 8'h50 | 8'(k);
        reset_models();

        // Reset state with valid inputs pending: no ack, outputs cleared.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid8", 64'(d8_v), 64'd0);
        chk("rst_data8",  64'(d8_data), 64'd0);
        chk("rst_ch8",    64'(d8_ch), 64'd0);
        chk("rst_ack8",   64'(d8_ack), 64'd0);
        chk("rst_ack5",   64'(d5_ack), 64'd0);
        #2 rst = 1'b0;
        m5_vin = 5'h00;

        // Manual-mode vector table on the N=8 instance.
        for (int i = 0; i < 8; i++) begin
            m8_sel = tbl[i].sel;
            m8_vin = tbl[i].vin;
            step();
            chk($sformatf("tbl%0d_ack", i), 64'(ack8), 64'(tbl[i].exp_ack));
            chk($sformatf("tbl%0d_v", i),   64'(d8_v), 64'(tbl[i].exp_v));
            chk($sformatf("tbl%0d_d", i),   64'(d8_data), 64'(tbl[i].exp_d));
            chk($sformatf("tbl%0d_ch", i),  64'(d8_ch), 64'(tbl[i].exp_ch));
        end

        // Auto scan, all enabled and valid: channel k carries k, wraps 7->0.
        for (int k = 0; k < 8; k++) m8_din[k*8 +: 8] = 8'(k);
        m8_mode = 1'b1; m8_en = 8'hFF; m8_vin = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("scan%0d_ch", i), 64'(d8_ch), 64'(i % 8));
            chk($sformatf("scan%0d_d", i),  64'(d8_data), 64'(i % 8));
        end

        // Mask: only ch0 and ch2 may win over one full scan.
        m8_en = 8'b0000_0101;
        caps = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ack8 != 8'h00) caps++;
        end
        chk("mask_caps", 64'(caps), 64'd2);

        // Backpressure: freeze for 3 cycles, then resume at the held pointer.
        m8_en = 8'hFF;
        step();
        hd = d8_data; hc = d8_ch;
        m8_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ack",  64'(ack8), 64'd0);
            chk("bp_data", 64'(d8_data), 64'(hd));
            chk("bp_ch",   64'(d8_ch), 64'(hc));
            chk("bp_v",    64'(d8_v), 64'd1);
        end
        m8_rdy = 1'b1;
        step();
        chk("bp_resume_ch", 64'(d8_ch), 64'((int'(hc) + 1) % 8));

        // Async reset mid-transfer: cleared before the next edge.
        chk("pre_rst_v", 64'(d8_v), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_v",    64'(d8_v), 64'd0);
        chk("mid_rst_data", 64'(d8_data), 64'd0);
        chk("mid_rst_ack",  64'(d8_ack), 64'd0);
        reset_models();
        #1 rst = 1'b0;
        step();
        chk("post_rst_ptr0", 64'(d8_ch), 64'd0);

        // Non-power-of-2: N=5 pointer 0..4,0; manual sel=6 captures nothing.
        m8_mode = 1'b0; m8_vin = 8'h00;
        m5_mode = 1'b1; m5_en = 5'h1F; m5_vin = 5'h1F;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("n5_scan%0d", i), 64'(d5_ch), 64'(i % 5));
        end
        m5_mode = 1'b0; m5_sel = 3'd6;
        step();
        chk("n5_sel6_ack", 64'(ack5), 64'd0);
        chk("n5_sel6_v",   64'(d5_v), 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            m8_mode = 1'($urandom_range(0, 1));
            m8_sel  = 3'($urandom);
            m8_en   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            m8_vin  = 8'($urandom);
            m8_din  = {$urandom, $urandom};
            m8_rdy  = ($urandom_range(0, 3) != 0);
            m5_mode = 1'($urandom_range(0, 1));
            m5_sel  = 3'($urandom);
            m5_en   = 5'($urandom);
            m5_vin  = 5'($urandom);
            m5_din  = {8'($urandom), $urandom};
            m5_rdy  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
